// File: rtl/cmos_stream_ctrl.sv
// Stream-side sequencer for the CMOS video input: gates the formatter enable on run/lock,
// snoops the outgoing AXI4-Stream for frame geometry, and keeps frame/error counters.
module cmos_stream_ctrl #(
    parameter int unsigned H_ACTIVE     = 1280,
    parameter int unsigned V_ACTIVE     = 720,
    parameter int unsigned LOCK_WAIT    = 16,
    parameter int unsigned FLUSH_CYCLES = 64
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        ctrl_run,
    input  logic        vtd_locked,
    input  logic        overflow,
    input  logic        s_tvalid,
    input  logic        s_tready,
    input  logic        s_tuser,
    input  logic        s_tlast,
    output logic        axis_enable,
    output logic [2:0]  state_o,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt,
    output logic        frame_irq
);

    localparam int unsigned TMax = (LOCK_WAIT > FLUSH_CYCLES) ? LOCK_WAIT : FLUSH_CYCLES;
    localparam int unsigned TW   = $clog2(TMax + 1);

    localparam logic [11:0]   HAct      = 12'(H_ACTIVE);
    localparam logic [11:0]   VAct      = 12'(V_ACTIVE);
    localparam logic [TW-1:0] LockWait  = TW'(LOCK_WAIT);
    localparam logic [TW-1:0] FlushLast = TW'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitLock = 3'd1,
        StArm      = 3'd2,
        StRun      = 3'd3,
        StFlush    = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [11:0]    pix_q, pix_d;
    logic [11:0]    line_q, line_d;
    logic           sof_exp_q, sof_exp_d;
    logic           axis_enable_q, axis_enable_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic [7:0]     err_cnt_q, err_cnt_d;
    logic           frame_irq_q, frame_irq_d;

    logic        beat;
    logic [11:0] pix_nxt;
    logic        geo_err;
    logic        frame_end;
    logic        take_beat;
    logic        err_inc;

    assign beat    = s_tvalid & s_tready;
    assign pix_nxt = pix_q + 12'd1;
    // A beat is wrong if its SOF flag disagrees with the expected frame position, or its EOL
    // flag disagrees with the line length.
    assign geo_err   = (s_tuser != sof_exp_q) ||
                       (s_tlast ? (pix_nxt != HAct) : (pix_nxt == HAct));
    assign frame_end = s_tlast && ((line_q + 12'd1) == VAct);

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        pix_d       = pix_q;
        line_d      = line_q;
        sof_exp_d   = sof_exp_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        frame_irq_d = 1'b0;
        take_beat   = 1'b0;
        err_inc     = 1'b0;

        unique case (state_q)
            StIdle: begin
                tmr_d = '0;
                if (ctrl_run) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (!ctrl_run) begin
                    state_d = StIdle;
                    tmr_d   = '0;
                end else if (!vtd_locked) begin
                    tmr_d = '0;
                end else if ((tmr_q + TW'(1)) >= LockWait) begin
                    state_d   = StArm;
                    tmr_d     = '0;
                    pix_d     = '0;
                    line_d    = '0;
                    sof_exp_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            StArm: begin
                if (overflow || !vtd_locked) err_inc = 1'b1;
                else if (!ctrl_run)          state_d = StIdle;
                else if (beat && s_tuser)    take_beat = 1'b1;
            end
            StRun: begin
                // A stop request between frames takes effect at once; mid-frame it waits.
                if (overflow || !vtd_locked)  err_inc = 1'b1;
                else if (!ctrl_run && sof_exp_q) state_d = StIdle;
                else if (beat)                take_beat = 1'b1;
            end
            StFlush: begin
                if (tmr_q == FlushLast) begin
                    state_d = ctrl_run ? StWaitLock : StIdle;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (take_beat) begin
            if (geo_err) begin
                err_inc = 1'b1;
            end else begin
                state_d   = StRun;
                sof_exp_d = 1'b0;
                if (s_tlast) begin
                    pix_d = '0;
                    if (frame_end) begin
                        line_d      = '0;
                        sof_exp_d   = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        frame_irq_d = 1'b1;
                        if (!ctrl_run) state_d = StIdle;
                    end else begin
                        line_d = line_q + 12'd1;
                    end
                end else begin
                    pix_d = pix_nxt;
                end
            end
        end

        if (err_inc) begin
            state_d = StFlush;
            tmr_d   = '0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end

        axis_enable_d = (state_d == StArm) || (state_d == StRun);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= StIdle;
            tmr_q         <= '0;
            pix_q         <= '0;
            line_q        <= '0;
            sof_exp_q     <= 1'b0;
            axis_enable_q <= 1'b0;
            frame_cnt_q   <= '0;
            err_cnt_q     <= '0;
            frame_irq_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            pix_q         <= pix_d;
            line_q        <= line_d;
            sof_exp_q     <= sof_exp_d;
            axis_enable_q <= axis_enable_d;
            frame_cnt_q   <= frame_cnt_d;
            err_cnt_q     <= err_cnt_d;
            frame_irq_q   <= frame_irq_d;
        end
    end

    assign axis_enable = axis_enable_q;
    assign state_o     = state_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign frame_irq   = frame_irq_q;

endmodule

// File: tb/tb_cmos_stream_ctrl.sv
// Bench for cmos_stream_ctrl: vector table, directed corner sequences and a randomized run,
// all checked every cycle against a frame-position reference model.
module tb_cmos_stream_ctrl;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int LW = 4;
    localparam int FC = 8;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        ctrl_run = 1'b0, vtd_locked = 1'b0, overflow = 1'b0;
    logic        s_tvalid = 1'b0, s_tready = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
    logic        axis_enable;
    logic [2:0]  state_o;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
    logic        frame_irq;

    always #5 aclk = ~aclk;

    cmos_stream_ctrl #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .LOCK_WAIT   (LW),
        .FLUSH_CYCLES(FC)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .ctrl_run   (ctrl_run),
        .vtd_locked (vtd_locked),
        .overflow   (overflow),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tuser    (s_tuser),
        .s_tlast    (s_tlast),
        .axis_enable(axis_enable),
        .state_o    (state_o),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt),
        .frame_irq  (frame_irq)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: modes 0..4 as the state codes; stream tracked as one position in frame.
    int m_mode, m_tmr, m_k, m_fcnt, m_ecnt;
    bit m_irq;

    typedef struct {
        bit run, lk, ovf, v, r, u, l;
        logic [2:0]  st;
        bit          en;
        logic [15:0] fc;
        logic [7:0]  ec;
        bit          irq;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_tmr = 0; m_k = 0; m_fcnt = 0; m_ecnt = 0; m_irq = 0;
    endtask

    task automatic model_step(input bit run, input bit lk, input bit ovf, input bit bt,
                              input bit u, input bit l);
        bit take;
        bit err;
        take  = 0;
        err   = 0;
        m_irq = 0;
        case (m_mode)
            0: if (run) m_mode = 1;
            1: begin
                if (!run) begin m_mode = 0; m_tmr = 0; end
                else if (!lk) m_tmr = 0;
                else begin
                    m_tmr++;
                    if (m_tmr >= LW) begin m_mode = 2; m_tmr = 0; m_k = 0; end
                end
            end
            2: begin
                if (ovf || !lk) err = 1;
                else if (!run) m_mode = 0;
                else if (bt && u) take = 1;
            end
            3: begin
                if (ovf || !lk) err = 1;
                else if (!run && m_k == 0) m_mode = 0;
                else if (bt) take = 1;
            end
            4: begin
                m_tmr++;
                if (m_tmr == FC) begin m_mode = run ? 1 : 0; m_tmr = 0; end
            end
            default: ;
        endcase
        if (take) begin
            if (u != (m_k == 0) || l != (m_k % H == H - 1)) err = 1;
            else if (m_k == H * V - 1) begin
                m_k = 0; m_fcnt++; m_irq = 1; m_mode = run ? 3 : 0;
            end else begin
                m_k++; m_mode = 3;
            end
        end
        if (err) begin
            if (m_ecnt < 255) m_ecnt++;
            m_mode = 4; m_tmr = 0;
        end
    endtask

    task automatic check_model();
        chk("state", state_o, m_mode);
        chk("axis_enable", axis_enable, (m_mode == 2 || m_mode == 3) ? 1 : 0);
        chk("frame_cnt", frame_cnt, m_fcnt & 32'hFFFF);
        chk("err_cnt", err_cnt, m_ecnt);
        chk("frame_irq", frame_irq, m_irq);
    endtask

    task automatic cyc(input bit run, input bit lk, input bit ovf, input bit v, input bit r,
                       input bit u, input bit l);
        ctrl_run = run; vtd_locked = lk; overflow = ovf;
        s_tvalid = v; s_tready = r; s_tuser = u; s_tlast = l;
        @(posedge aclk);
        model_step(run, lk, ovf, v & r, u, l);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        ctrl_run = 0; vtd_locked = 0; overflow = 0;
        s_tvalid = 0; s_tready = 0; s_tuser = 0; s_tlast = 0;
        model_reset();
        @(posedge aclk);
        #1;
        chk("rst_state", state_o, 0);
        chk("rst_en", axis_enable, 0);
        chk("rst_fcnt", frame_cnt, 0);
        chk("rst_ecnt", err_cnt, 0);
        chk("rst_irq", frame_irq, 0);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic arm();
        repeat (LW + 1) cyc(1, 1, 0, 0, 0, 0, 0);
        chk("armed", state_o, 2);
    endtask

    task automatic beat(input bit u, input bit l, input bit run);
        cyc(run, 1, 0, 1, 1, u, l);
    endtask

    task automatic clean_frame();
        for (int k = 0; k < H * V; k++) beat(k == 0, (k % H) == H - 1, 1);
    endtask

    function automatic vec_t mk(input bit run, input bit lk, input bit v, input bit u,
                                input bit l, input logic [2:0] st, input bit en,
                                input logic [15:0] fc, input bit irq);
        vec_t r;
        r.run = run; r.lk = lk; r.ovf = 0; r.v = v; r.r = 1; r.u = u; r.l = l;
        r.st = st; r.en = en; r.fc = fc; r.ec = 0; r.irq = irq;
        return r;
    endfunction

    initial begin
        // Vector table: lock-in, a discarded pre-SOF beat, then two clean frames.
        for (int i = 0; i < LW; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 3'd1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 3'd2, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 3'd2, 1, 0, 0));
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < H * V; k++)
                tbl.push_back(mk(1, 1, 1, k == 0, (k % H) == H - 1, 3'd3, 1,
                                 16'(f + ((k == H * V - 1) ? 1 : 0)), k == H * V - 1));
            tbl.push_back(mk(1, 1, 0, 1, 0, 3'd3, 1, 16'(f + 1), 0));
        end

        do_reset();
        foreach (tbl[i]) begin
            cyc(tbl[i].run, tbl[i].lk, tbl[i].ovf, tbl[i].v, tbl[i].r, tbl[i].u, tbl[i].l);
            chk($sformatf("tbl%0d_state", i), state_o, tbl[i].st);
            chk($sformatf("tbl%0d_en", i), axis_enable, tbl[i].en);
            chk($sformatf("tbl%0d_fcnt", i), frame_cnt, tbl[i].fc);
            chk($sformatf("tbl%0d_ecnt", i), err_cnt, tbl[i].ec);
            chk($sformatf("tbl%0d_irq", i), frame_irq, tbl[i].irq);
        end

        // Short second line: error, exact flush length, relock, then a clean frame.
        do_reset();
        arm();
        for (int k = 0; k < H; k++) beat(k == 0, k == H - 1, 1);
        beat(0, 0, 1); beat(0, 0, 1); beat(0, 1, 1);
        chk("short_ecnt", err_cnt, 1);
        chk("short_state", state_o, 4);
        chk("short_en", axis_enable, 0);
        repeat (FC - 1) cyc(1, 1, 0, 0, 0, 0, 0);
        chk("flush_hold", state_o, 4);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("flush_exit", state_o, 1);
        repeat (LW) cyc(1, 1, 0, 0, 0, 0, 0);
        chk("rearm", state_o, 2);
        clean_frame();
        chk("rearm_fcnt", frame_cnt, 1);
        chk("rearm_ecnt", err_cnt, 1);

        // Overflow coincident with a short-line tlast counts once; overflow in flush ignored.
        do_reset();
        arm();
        beat(1, 0, 1); beat(0, 0, 1);
        cyc(1, 1, 1, 1, 1, 0, 1);
        chk("ovf_ecnt", err_cnt, 1);
        chk("ovf_state", state_o, 4);
        cyc(1, 1, 1, 0, 0, 0, 0);
        chk("ovf_flush_ecnt", err_cnt, 1);

        // Run dropped mid-frame: frame completes, then idle on the same edge.
        do_reset();
        arm();
        for (int k = 0; k < H * V; k++) beat(k == 0, (k % H) == H - 1, k < 6);
        chk("stop_state", state_o, 0);
        chk("stop_en", axis_enable, 0);
        chk("stop_fcnt", frame_cnt, 1);
        chk("stop_irq", frame_irq, 1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("stop_irq_clr", frame_irq, 0);

        // Ready gaps and tuser/tlast noise on non-beats.
        do_reset();
        arm();
        begin
            int k;
            k = 0;
            for (int n = 0; n < 400 && k < H * V; n++) begin
                bit v, r, u, l;
                v = $urandom_range(0, 99) < 70;
                r = $urandom_range(0, 99) < 60;
                u = v ? (k == 0) : 1'($urandom_range(0, 1));
                l = v ? ((k % H) == H - 1) : 1'($urandom_range(0, 1));
                if (v && r) begin
                    if (!r) u = ~u;
                    k++;
                end else if (v) begin
                    u = 1'($urandom_range(0, 1));
                end
                cyc(1, 1, 0, v, r, u, l);
            end
            chk("gaps_stream_done", k, H * V);
        end
        chk("gaps_fcnt", frame_cnt, 1);
        chk("gaps_ecnt", err_cnt, 0);

        // Error counter saturation.
        do_reset();
        arm();
        for (int i = 0; i < 300; i++) begin
            cyc(1, 1, 1, 0, 0, 0, 0);
            if (i == 0) chk("sat_first", err_cnt, 1);
            repeat (FC + LW) cyc(1, 1, 0, 0, 0, 0, 0);
        end
        chk("sat_ecnt", err_cnt, 255);

        // Asynchronous reset mid-frame, between clock edges.
        do_reset();
        arm();
        clean_frame();
        for (int k = 0; k < 5; k++) beat(k == 0, (k % H) == H - 1, 1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_state", state_o, 0);
        chk("arst_en", axis_enable, 0);
        chk("arst_fcnt", frame_cnt, 0);
        chk("arst_irq", frame_irq, 0);
        model_reset();
        @(negedge aclk);
        aresetn = 1'b1;

        // Randomized stream with occasional corruption, lock loss, overflow and stop requests.
        begin
            int g;
            g = 0;
            for (int n = 0; n < 3000; n++) begin
                bit run, lk, ovf, v, r, u, l;
                run = $urandom_range(0, 99) < 96;
                lk  = $urandom_range(0, 99) < 98;
                ovf = $urandom_range(0, 199) < 1;
                v   = $urandom_range(0, 99) < 80;
                r   = $urandom_range(0, 99) < 85;
                u   = (g == 0);
                l   = (g % H) == H - 1;
                if ($urandom_range(0, 99) < 2) u = ~u;
                if ($urandom_range(0, 99) < 2) l = ~l;
                if (!v) u = 1'($urandom_range(0, 1));
                if (v && r) g = (g + 1) % (H * V);
                cyc(run, lk, ovf, v, r, u, l);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
